// File: rtl/rcvfifo_pkg.sv
// rcvfifo_pkg: receive FSM state encodings and baud constants, also used by the transmitter.
package rcvfifo_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rx_state_e;

    localparam logic [15:0] BIT_LEN_115200_50M = 16'd434;

endpackage

// File: rtl/rcvfifo_mem.sv
// rcvfifo_mem: first-word-fall-through byte FIFO; a push into a full FIFO is dropped unless a pop frees a slot in the same cycle.
module rcvfifo_mem #(
    parameter int DEPTH_LOG2 = 2,
    parameter int W          = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

    logic [W-1:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  wr_en, rd_en;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == (DEPTH_LOG2+1)'(DEPTH);
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_q + (DEPTH_LOG2+1)'(wr_en) - (DEPTH_LOG2+1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/rcvfifo.sv
// rcvfifo: 8N1 serial receiver with a byte FIFO, ready/read handshake and sticky framing/overrun flags.
module rcvfifo
    import rcvfifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bit_len,
    input  logic        serial_in,
    input  logic        read,
    output logic        ready,
    output logic [7:0]  data_out,
    output logic        frame_err,
    output logic        overrun,
    input  logic        clr_err
);

    logic [1:0]  sync_q;
    rx_state_e   state_q;
    logic [15:0] timer_q;
    logic [2:0]  bitcnt_q;
    logic [7:0]  shreg_q;
    logic        frame_err_q, overrun_q;
    logic        sync, tick, push, pop, stop_bad, empty, full;

    assign sync      = sync_q[1];
    assign tick      = timer_q == 16'd0;
    assign push      = state_q == S_STOP && tick && sync;
    assign stop_bad  = state_q == S_STOP && tick && !sync;
    assign pop       = read && !empty;
    assign ready     = !empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], serial_in};
    end

    // The timer free-runs down to zero and parks there; states reload it when they need a new interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
        end else begin
            timer_q <= tick ? timer_q : timer_q - 16'd1;
            case (state_q)
                S_IDLE: if (!sync) begin
                    timer_q <= bit_len >> 1;
                    state_q <= S_START;
                end
                S_START: if (tick) begin
                    if (sync) state_q <= S_IDLE;
                    else begin
                        timer_q  <= bit_len - 16'd1;
                        bitcnt_q <= '0;
                        state_q  <= S_DATA;
                    end
                end
                S_DATA: if (tick) begin
                    shreg_q  <= {sync, shreg_q[7:1]};
                    timer_q  <= bit_len - 16'd1;
                    bitcnt_q <= bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_q <= S_STOP;
                end
                S_STOP:  if (tick) state_q <= sync ? S_IDLE : S_BREAK;
                S_BREAK: if (sync) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= stop_bad || (frame_err_q && !clr_err);
            overrun_q   <= (push && full && !pop) || (overrun_q && !clr_err);
        end
    end

    rcvfifo_mem #(.DEPTH_LOG2(DEPTH_LOG2), .W(8)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (shreg_q),
        .dout_o  (data_out),
        .empty_o (empty),
        .full_o  (full)
    );

endmodule

// File: tb/tb_rcvfifo.sv
// tb_rcvfifo: drives 8N1 frames into rcvfifo and checks received bytes against a scoreboard queue.
module tb_rcvfifo;
    import rcvfifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bit_len = 16'd16;
    logic        serial_in = 1'b1;
    logic        read = 1'b0;
    logic        clr_err = 1'b0;
    logic        ready, frame_err, overrun;
    logic [7:0]  data_out;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [7:0]  exp_q[$];

    rcvfifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_len   (bit_len),
        .serial_in (serial_in),
        .read      (read),
        .ready     (ready),
        .data_out  (data_out),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h want %0h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic wait_bits(input int n);
        repeat (n * int'(bit_len)) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input logic expect_it);
        if (expect_it) exp_q.push_back(b);
        serial_in = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            wait_bits(1);
        end
        serial_in = stop;
        wait_bits(1);
        serial_in = 1'b1;
    endtask

    task automatic rd(input string tag);
        int k = 0;
        logic [7:0] e;
        while (!ready && k < 20 * int'(bit_len) + 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_rdy"}, 32'(ready), 32'd1);
        e = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
        chk(tag, 32'(data_out), 32'(e));
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic rand_phase(input int n);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    send_byte(b, 1'b1, 1'b1);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < n; i++) begin
                    repeat ($urandom_range(0, 40)) @(negedge clk);
                    rd("t6_data");
                end
            end
        join
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_byte(8'hA5, 1'b1, 1'b1);
        chk("t1_ready", 32'(ready), 32'd1);
        rd("t1_data");
        chk("t1_empty", 32'(ready), 32'd0);

        send_byte(8'h01, 1'b1, 1'b1);
        send_byte(8'h80, 1'b1, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1);
        send_byte(8'h00, 1'b1, 1'b1);
        chk("t2_cnt", 32'(dut.u_mem.count_q), 32'd4);
        chk("t2_ovr", 32'(overrun), 32'd0);

        send_byte(8'h3C, 1'b1, 1'b0);
        chk("t3_ovr", 32'(overrun), 32'd1);
        chk("t3_head", 32'(data_out), 32'h01);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t3_clr", 32'(overrun), 32'd0);
        fork
            send_byte(8'h77, 1'b1, 1'b1);
            begin
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!dut.push && k < 400);
                chk("t3_push_seen", 32'(dut.push), 32'd1);
                chk("t3_pop_head", 32'(data_out), 32'(exp_q.pop_front()));
                read = 1'b1;
                @(negedge clk);
                read = 1'b0;
            end
        join
        chk("t3_ovr_simul", 32'(overrun), 32'd0);
        chk("t3_cnt", 32'(dut.u_mem.count_q), 32'd4);
        for (int i = 0; i < 4; i++) rd("t3_data");
        chk("t3_empty", 32'(ready), 32'd0);

        send_byte(8'h55, 1'b0, 1'b0);
        serial_in = 1'b0;
        wait_bits(3);
        chk("t4_ferr", 32'(frame_err), 32'd1);
        chk("t4_nopush", 32'(ready), 32'd0);
        chk("t4_break", 32'(dut.state_q), 32'(S_BREAK));
        serial_in = 1'b1;
        wait_bits(1);
        send_byte(8'h12, 1'b1, 1'b1);
        rd("t4_data");
        chk("t4_ferr_held", 32'(frame_err), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t4_ferr_clr", 32'(frame_err), 32'd0);

        serial_in = 1'b0;
        repeat (int'(bit_len >> 1) - 2) @(negedge clk);
        serial_in = 1'b1;
        wait_bits(2);
        chk("t5_glitch_ready", 32'(ready), 32'd0);
        chk("t5_glitch_idle", 32'(dut.state_q), 32'(S_IDLE));
        serial_in = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 4; i++) begin
            serial_in = i[0];
            wait_bits(1);
        end
        rst_n = 1'b0;
        serial_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_bits(2);
        chk("t5_rst_ready", 32'(ready), 32'd0);
        send_byte(8'h9C, 1'b1, 1'b1);
        rd("t5_data");
        chk("t5_only", 32'(ready), 32'd0);

        rand_phase(24);
        bit_len = BIT_LEN_115200_50M;
        rand_phase(3);
        chk("t6_ferr", 32'(frame_err), 32'd0);
        chk("t6_ovr", 32'(overrun), 32'd0);
        chk("t6_empty", 32'(ready), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
